// File: rtl/memory_access.sv
// Memory-stage data access: issues dmem requests, stalls on wait states,
// aligns load/store data and registers the M->W pipeline stage.
module memory_access #(
   parameter  int unsigned TIMEOUT = 255,
   localparam int unsigned XLEN    = 32,
   localparam int unsigned RW      = 5,
   localparam int unsigned BEW     = XLEN / 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            reg_wrM,
   input  logic            mem_wrM,
   input  logic [1:0]      result_srcM,
   input  logic [2:0]      funct3M,
   input  logic [XLEN-1:0] ALU_resultM,
   input  logic [XLEN-1:0] wr_dataM,
   input  logic [XLEN-1:0] PCp4M,
   input  logic [RW-1:0]   rdM,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [BEW-1:0]  dmem_be,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_ready,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            stallM,
   output logic            reg_wrW,
   output logic [1:0]      result_srcW,
   output logic [XLEN-1:0] ALU_resultW,
   output logic [XLEN-1:0] read_dataW,
   output logic [XLEN-1:0] PCp4W,
   output logic [RW-1:0]   rdW,
   output logic            misalignW,
   output logic            bus_errW
);

   localparam int unsigned CW = 8;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_wait_cnt, w_wait_cnt_nxt;
   logic            w_mem_op, w_misalign;
   logic            w_req, w_stall, w_load_w, w_bus_err, w_mis_done;
   logic [1:0]      w_off;
   logic [7:0]      w_byte;
   logic [15:0]     w_half;
   logic [XLEN-1:0] w_load_data;

   assign w_off    = ALU_resultM[1:0];
   assign w_mem_op = (result_srcM == 2'b01) | mem_wrM;
   assign w_misalign = ((funct3M[1:0] == 2'b01) & w_off[0]) |
                       ((funct3M[1:0] == 2'b10) & (w_off != 2'b00));

   // Bus-side outputs are combinational and forced quiet while in reset
   assign dmem_req  = rst & w_req;
   assign stallM    = rst & w_stall;
   assign dmem_we   = dmem_req & mem_wrM;
   assign dmem_addr = {ALU_resultM[XLEN-1:2], 2'b00};

   always_comb begin
      dmem_be    = 4'b1111;
      dmem_wdata = wr_dataM;
      case (funct3M[1:0])
         2'b00: begin
            dmem_be    = 4'(4'b0001 << w_off);
            dmem_wdata = {4{wr_dataM[7:0]}};
         end
         2'b01: begin
            dmem_be    = 4'(4'b0011 << w_off);
            dmem_wdata = {2{wr_dataM[15:0]}};
         end
         default: ;
      endcase
   end

   assign w_byte = 8'(dmem_rdata >> {w_off, 3'b000});
   assign w_half = 16'(dmem_rdata >> {w_off[1], 4'b0000});

   always_comb begin
      w_load_data = dmem_rdata;
      case (funct3M)
         3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
         3'b100:  w_load_data = {24'd0, w_byte};
         3'b101:  w_load_data = {16'd0, w_half};
         default: w_load_data = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
      end
   end

   // Next state, request/stall and W-stage load decision
   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      w_req          = 1'b0;
      w_stall        = 1'b0;
      w_load_w       = 1'b0;
      w_bus_err      = 1'b0;
      w_mis_done     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_wait_cnt_nxt = '0;
            if (!w_mem_op) begin
               w_load_w = 1'b1;
            end else if (w_misalign) begin
               w_load_w   = 1'b1;
               w_mis_done = 1'b1;
            end else begin
               w_req = 1'b1;
               if (dmem_ready) begin
                  w_load_w = 1'b1;
               end else begin
                  w_stall     = 1'b1;
                  w_state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            w_req = 1'b1;
            if (dmem_ready) begin
               w_load_w    = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (r_wait_cnt == CW'(TIMEOUT - 1)) begin
               w_load_w    = 1'b1;
               w_bus_err   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_stall        = 1'b1;
               w_wait_cnt_nxt = r_wait_cnt + CW'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // W pipeline register; a stall cycle inserts a bubble
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reg_wrW     <= 1'b0;
         result_srcW <= '0;
         ALU_resultW <= '0;
         read_dataW  <= '0;
         PCp4W       <= '0;
         rdW         <= '0;
         misalignW   <= 1'b0;
         bus_errW    <= 1'b0;
      end else if (w_load_w) begin
         reg_wrW     <= reg_wrM & ~w_mis_done & ~w_bus_err;
         result_srcW <= result_srcM;
         ALU_resultW <= ALU_resultM;
         read_dataW  <= w_load_data;
         PCp4W       <= PCp4M;
         rdW         <= rdM;
         misalignW   <= w_mis_done;
         bus_errW    <= w_bus_err;
      end else begin
         reg_wrW   <= 1'b0;
         misalignW <= 1'b0;
         bus_errW  <= 1'b0;
      end
   end

endmodule
